can_ctrl_axil_master: RTL and testbench

//   AXI4-Lite initiator that drives the CAN controller's s_axi_control register port from a

---
 rtl/can_axil_pkg.sv | 23 ++
 rtl/can_ctrl_axil_master.sv | 194 +++++++++++++++++++
 tb/tb_can_ctrl_axil_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_axil_pkg.sv
// Shared types and constants for the CAN control-port AXI4-Lite master.
package can_axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 32;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/can_ctrl_axil_master.sv
// Single-outstanding request/response to AXI4-Lite master for the CAN control slave.
// Optional wait-state timeout enabled by defining CAN_MST_TIMEOUT_EN.
module can_ctrl_axil_master
    import can_axil_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    state_e              state_q;
    logic                aw_done_q, w_done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic aw_hs, w_hs, wr_both_done;
    logic unused_addr_lsbs;

    assign aw_hs        = awvalid_q && m_awready;
    assign w_hs         = wvalid_q && m_wready;
    assign wr_both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    // Word-aligned slave: the byte offset bits never reach the bus.
    assign unused_addr_lsbs = ^req_addr[1:0];

`ifdef CAN_MST_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             in_wait, leave_wait, timeout_hit;

    assign in_wait    = (state_q == WR_AW_W) || (state_q == WR_B) ||
                        (state_q == RD_AR)   || (state_q == RD_R);
    assign leave_wait = ((state_q == WR_AW_W) && wr_both_done) ||
                        ((state_q == WR_B)    && m_bvalid)     ||
                        ((state_q == RD_AR)   && m_arready)    ||
                        ((state_q == RD_R)    && m_rvalid);
    // A handshake landing on the last allowed cycle still completes normally.
    assign timeout_hit = in_wait && !leave_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef CAN_MST_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= {req_addr[ADDR_W-1:2], 2'b00};
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (req_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_AW_W;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_AR;
                        end
                    end
                end
                WR_AW_W: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (wr_both_done) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= resp_is_err(m_bresp);
                        rsp_rdata_q <= '0;
                        state_q     <= RSP;
                    end
                end
                RD_AR: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= resp_is_err(m_rresp);
                        rsp_rdata_q <= m_rdata;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef CAN_MST_TIMEOUT_EN
            cnt_q <= (in_wait && !leave_wait) ? cnt_q + 1'b1 : '0;
            if (timeout_hit) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
                cnt_q       <= '0;
                state_q     <= RSP;
            end
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_awaddr  = addr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_can_ctrl_axil_master.sv
// Self-checking bench: directed vector table, randomized traffic against a word-memory
// reference model, reset-abort sequence and (with CAN_MST_TIMEOUT_EN) a timeout sequence.
module tb_can_ctrl_axil_master;
    import can_axil_pkg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [6:0]  m_awaddr, m_araddr;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
    logic [31:0] m_rdata = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] slv_mem [32];
    logic [31:0] ref_mem [32];

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    can_ctrl_axil_master #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [6:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int aw_d, input int w_d, input int b_d,
                                input int ar_d, input int r_d, input logic [1:0] resp, input int hold,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
        v.resp = resp; v.hold = hold;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Reference write: byte-mask blend of old word and new data.
    function automatic logic [31:0] ref_write(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    // Drives one request from the current negedge, plays the AXI slave, checks the response.
    task automatic run_txn(input vec_t v, input string tag);
        int k, aw_cyc, w_cyc, ar_cyc, b_cnt, r_cnt, wr_max;
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_done, got;
        bit pend_aw, pend_w, pend_b, pend_ar, pend_r;
        logic [6:0]  cap_aw, cap_ar, exp_addr;
        logic [31:0] cap_wd, old_word;
        logic [3:0]  cap_ws;
        k = 0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; b_cnt = 0; r_cnt = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; wr_done = 0; got = 0;
        pend_aw = 0; pend_w = 0; pend_b = 0; pend_ar = 0; pend_r = 0;
        cap_aw = '0; cap_ar = '0; cap_wd = '0; cap_ws = '0;
        exp_addr = {v.addr[6:2], 2'b00};
        check({tag, " req_ready idle"}, req_ready, 1);
        req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        while (!got && k < 200) begin
            @(negedge ap_clk);
            k++;
            req_valid = 0;
            if (pend_aw) begin aw_hs = 1; aw_cyc = k - 1; end
            if (pend_w)  begin w_hs = 1;  w_cyc = k - 1;  end
            if (pend_ar) begin ar_hs = 1; ar_cyc = k - 1; end
            if (pend_b)  begin b_hs = 1;  b_cnt++; end
            if (pend_r)  begin r_hs = 1;  r_cnt++; end
            if (aw_hs && w_hs && !wr_done) begin
                wr_done = 1;
                old_word = slv_mem[cap_aw[6:2]];
                for (int b = 0; b < 4; b++)
                    if (cap_ws[b]) old_word[8*b +: 8] = cap_wd[8*b +: 8];
                slv_mem[cap_aw[6:2]] = old_word;
            end
            if (k == 1) begin
                check({tag, " req_ready busy"}, req_ready, 0);
                check({tag, " valids T+1"}, {m_awvalid, m_wvalid, m_arvalid}, v.we ? 3'b110 : 3'b001);
            end
            if (aw_hs && k == aw_cyc + 1) check({tag, " awvalid drop"}, m_awvalid, 0);
            if (w_hs && k == w_cyc + 1)   check({tag, " wvalid drop"}, m_wvalid, 0);
            if (ar_hs && k == ar_cyc + 1) check({tag, " arvalid drop"}, m_arvalid, 0);
            if (rsp_valid) got = 1;
            wr_max = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
            m_awready = m_awvalid && !aw_hs && (k >= 1 + v.aw_d);
            if (m_awready) begin
                cap_aw = m_awaddr;
                check({tag, " awaddr"}, m_awaddr, exp_addr);
            end
            m_wready = m_wvalid && !w_hs && (k >= 1 + v.w_d);
            if (m_wready) begin
                cap_wd = m_wdata; cap_ws = m_wstrb;
                check({tag, " wdata/wstrb"}, {m_wdata, m_wstrb}, {v.wdata, v.wstrb});
            end
            m_bvalid = wr_done && !b_hs && (k >= wr_max + 1 + v.b_d);
            m_bresp  = m_bvalid ? v.resp : 2'b00;
            m_arready = m_arvalid && !ar_hs && (k >= 1 + v.ar_d);
            if (m_arready) begin
                cap_ar = m_araddr;
                check({tag, " araddr"}, m_araddr, exp_addr);
            end
            m_rvalid = ar_hs && !r_hs && (k >= ar_cyc + 1 + v.r_d);
            m_rdata  = m_rvalid ? slv_mem[cap_ar[6:2]] : 32'h0;
            m_rresp  = m_rvalid ? v.resp : 2'b00;
            pend_aw = m_awvalid && m_awready;
            pend_w  = m_wvalid && m_wready;
            pend_b  = m_bvalid && m_bready;
            pend_ar = m_arvalid && m_arready;
            pend_r  = m_rvalid && m_rready;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s rsp_wait actual=none required=rsp_valid within 200 cycles", tag);
        end else begin
            check({tag, " latency"}, k, v.exp_lat);
            check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
            check({tag, " rsp_err"}, rsp_err, v.exp_err);
            check({tag, " one B/R"}, v.we ? b_cnt : r_cnt, 1);
            for (int h = 0; h < v.hold; h++) begin
                rsp_ready = 0;
                @(negedge ap_clk);
                check({tag, " rsp held"}, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, v.exp_err, v.exp_rdata});
            end
            rsp_ready = 1;
            @(negedge ap_clk);
            rsp_ready = 0;
            check({tag, " rsp done"}, {rsp_valid, req_ready}, 2'b01);
        end
    endtask

    initial begin
        vec_t rv;
        int   k, n;
        bit   got;
        for (int i = 0; i < 32; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end

        //          we    addr   wdata         strb  aw w  b  ar r  resp         hold exp_rdata     err lat
        vecs[0] = mk(1'b1, 7'h14, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY,   0, 32'h0,         0, 3);
        vecs[1] = mk(1'b1, 7'h08, 32'hCAFE_0001, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY,   0, 32'h0,         0, 3);
        vecs[2] = mk(1'b0, 7'h08, 32'h0,         4'h0, 0, 0, 0, 3, 0, RESP_OKAY,   0, 32'hCAFE_0001, 0, 6);
        vecs[3] = mk(1'b1, 7'h20, 32'hDEAD_BEEF, 4'hF, 0, 3, 0, 0, 0, RESP_OKAY,   0, 32'h0,         0, 6);
        vecs[4] = mk(1'b0, 7'h14, 32'h0,         4'h0, 0, 0, 0, 0, 0, RESP_SLVERR, 5, 32'h1234_5678, 1, 3);
        vecs[5] = mk(1'b1, 7'h16, 32'hAAAA_BBBB, 4'h3, 0, 0, 2, 0, 0, RESP_SLVERR, 0, 32'h0,         1, 5);
        vecs[6] = mk(1'b0, 7'h17, 32'h0,         4'h0, 0, 0, 0, 0, 2, RESP_OKAY,   1, 32'h1234_BBBB, 0, 5);
        vecs[7] = mk(1'b1, 7'h20, 32'hFFFF_FFFF, 4'h0, 2, 1, 0, 0, 0, RESP_OKAY,   0, 32'h0,         0, 5);
        vecs[8] = mk(1'b0, 7'h20, 32'h0,         4'h0, 0, 0, 0, 1, 1, RESP_OKAY,   0, 32'hDEAD_BEEF, 0, 5);
        vecs[9] = mk(1'b0, 7'h7C, 32'h0,         4'h0, 0, 0, 0, 0, 0, RESP_OKAY,   2, 32'h0,         0, 3);

        #3;
        check("reset ctrl", {req_ready, rsp_valid, rsp_err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready},
              8'b1000_0000);
        check("reset data", {m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata}, 0);
        @(negedge ap_clk);
        ap_rst = 0;
        @(negedge ap_clk);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].we)
                ref_mem[vecs[i].addr[6:2]] = ref_write(ref_mem[vecs[i].addr[6:2]], vecs[i].wdata, vecs[i].wstrb);
        end

        for (int i = 0; i < 40; i++) begin
            rv.we    = 1'($urandom_range(0, 1));
            rv.addr  = 7'($urandom);
            rv.wdata = $urandom;
            rv.wstrb = 4'($urandom);
            rv.aw_d  = $urandom_range(0, 4);
            rv.w_d   = $urandom_range(0, 4);
            rv.b_d   = $urandom_range(0, 4);
            rv.ar_d  = $urandom_range(0, 4);
            rv.r_d   = $urandom_range(0, 4);
            rv.resp  = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
            rv.hold  = $urandom_range(0, 3);
            rv.exp_err = (rv.resp != RESP_OKAY);
            if (rv.we) begin
                rv.exp_rdata = '0;
                rv.exp_lat   = ((rv.aw_d > rv.w_d) ? rv.aw_d : rv.w_d) + rv.b_d + 3;
            end else begin
                rv.exp_rdata = ref_mem[rv.addr[6:2]];
                rv.exp_lat   = rv.ar_d + rv.r_d + 3;
            end
            run_txn(rv, $sformatf("rnd%0d", i));
            if (rv.we) ref_mem[rv.addr[6:2]] = ref_write(ref_mem[rv.addr[6:2]], rv.wdata, rv.wstrb);
        end

        // Reset while waiting for B: everything drops at once and no response follows.
        req_valid = 1; req_we = 1; req_addr = 7'h30; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
        @(negedge ap_clk);
        req_valid = 0; m_awready = 1; m_wready = 1;
        @(negedge ap_clk);
        m_awready = 0; m_wready = 0;
        check("rst in WR_B", {m_bready, m_awvalid, m_wvalid}, 3'b100);
        #2 ap_rst = 1;
        #1;
        check("rst async ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, req_ready}, 7'b0000001);
        check("rst async data", {m_awaddr, m_wdata, m_wstrb}, 0);
        @(negedge ap_clk);
        ap_rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            check("rst after release", {req_ready, rsp_valid}, 2'b10);
        end

`ifdef CAN_MST_TIMEOUT_EN
        req_valid = 1; req_we = 0; req_addr = 7'h04;
        k = 0; n = 0; got = 0;
        while (!got && k < 100) begin
            @(negedge ap_clk);
            k++;
            req_valid = 0;
            if (m_arvalid) n++;
            if (rsp_valid) got = 1;
        end
        check("timeout arvalid cycles", n, 16);
        check("timeout rsp cycle", k, 17);
        check("timeout rsp", {rsp_valid, rsp_err, rsp_rdata, m_arvalid}, {1'b1, 1'b1, 32'h0, 1'b0});
        rsp_ready = 1;
        @(negedge ap_clk);
        rsp_ready = 0;
        check("timeout rsp done", {rsp_valid, req_ready}, 2'b01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
